// File: rtl/vend_sequencer.sv
// vend_sequencer: keypad/coin vending sequencer.
// The user picks a product id, sees it for a while, then feeds coins.
// The sequencer vends with change, refunds on error or cancel, and rejects
// coins it cannot accept. All outputs come straight from registers.
module vend_sequencer #(
    parameter int unsigned PRICE       = 4,
    parameter logic [15:0] VALID_MASK  = 16'h0FFF,
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [1:0] key_row_i,
    input  logic [1:0] key_col_i,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_val_i,
    input  logic       cancel_i,
    output logic [2:0] state_o,
    output logic [3:0] val_tot_o,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic       vend_o,
    output logic [3:0] change_o,
    output logic       refund_o,
    output logic [3:0] refund_val_o,
    output logic       coin_reject_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_SHOW_ID = 3'b001,
        ST_COIN    = 3'b010,
        ST_DONE    = 3'b011,
        ST_ERR_ID  = 3'b100,
        ST_ERR_VAL = 3'b101
    } state_t;

    // Credit never exceeds the display range 0.00..2.00.
    localparam logic [4:0]  MAX_CREDIT = 5'd8;
    localparam logic [4:0]  PRICE_W    = 5'(PRICE);
    localparam logic [26:0] SHOW_LAST  = 27'(SHOW_CYCLES - 1);
    localparam logic [26:0] HOLD_LAST  = 27'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [3:0]  val_tot_q, val_tot_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        vend_q, vend_d;
    logic [3:0]  change_q, change_d;
    logic        refund_q, refund_d;
    logic [3:0]  refund_val_q, refund_val_d;
    logic        coin_reject_q, coin_reject_d;

    logic [2:0]  coin_amt_s;
    logic        coin_bad_s;
    logic [4:0]  new_sum_s;
    logic        counting_s;

    // Decode the coin code into its value in 0.25 units; code 11 is worth nothing.
    always_comb begin
        coin_amt_s = 3'd0;
        coin_bad_s = 1'b0;
        case (coin_val_i)
            2'b00:   coin_amt_s = 3'd1;
            2'b01:   coin_amt_s = 3'd2;
            2'b10:   coin_amt_s = 3'd4;
            default: coin_bad_s = 1'b1;
        endcase
        new_sum_s = {1'b0, val_tot_q} + {2'b00, coin_amt_s};
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        val_tot_d     = val_tot_q;
        row_d         = row_q;
        col_d         = col_q;
        vend_d        = 1'b0;
        change_d      = 4'd0;
        refund_d      = 1'b0;
        refund_val_d  = 4'd0;
        coin_reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                coin_reject_d = coin_valid_i;
                if (key_valid_i) begin
                    row_d   = key_row_i;
                    col_d   = key_col_i;
                    state_d = ST_SHOW_ID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW_ID: begin
                // Cancel wins; any coin arriving here is handed back.
                coin_reject_d = coin_valid_i;
                if (cancel_i) begin
                    state_d      = ST_IDLE;
                    val_tot_d    = 4'd0;
                    refund_d     = (val_tot_q != 4'd0);
                    refund_val_d = val_tot_q;
                end else if ((cnt_q == 27'd0) && !VALID_MASK[{row_q, col_q}]) begin
                    state_d = ST_ERR_ID;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = ST_COIN;
                end else begin
                    state_d = ST_SHOW_ID;
                end
            end
            ST_COIN: begin
                if (cancel_i) begin
                    // A coin in the same cycle as cancel is never credited.
                    state_d       = ST_IDLE;
                    val_tot_d     = 4'd0;
                    refund_d      = (val_tot_q != 4'd0);
                    refund_val_d  = val_tot_q;
                    coin_reject_d = coin_valid_i;
                end else if (coin_valid_i) begin
                    if (coin_bad_s || (new_sum_s > MAX_CREDIT)) begin
                        // Return everything the user has put in, including this coin.
                        state_d      = ST_ERR_VAL;
                        refund_d     = 1'b1;
                        refund_val_d = new_sum_s[3:0];
                    end else if (new_sum_s >= PRICE_W) begin
                        state_d   = ST_DONE;
                        val_tot_d = new_sum_s[3:0];
                        vend_d    = 1'b1;
                        change_d  = 4'(new_sum_s - PRICE_W);
                    end else begin
                        val_tot_d = new_sum_s[3:0];
                    end
                end else begin
                    state_d = ST_COIN;
                end
            end
            ST_DONE, ST_ERR_ID, ST_ERR_VAL: begin
                // Cancel and keys are ignored while a result is displayed.
                coin_reject_d = coin_valid_i;
                if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    val_tot_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                val_tot_d = 4'd0;
            end
        endcase
    end

    // Dwell counter: restarts on every state change, runs only in timed states.
    always_comb begin
        counting_s = (state_q == ST_SHOW_ID) || (state_q == ST_DONE) ||
                     (state_q == ST_ERR_ID)  || (state_q == ST_ERR_VAL);
        if (state_d != state_q) begin
            cnt_d = 27'd0;
        end else if (counting_s) begin
            cnt_d = cnt_q + 27'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counter and output registers; reset discards credit silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 27'd0;
            val_tot_q     <= 4'd0;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            vend_q        <= 1'b0;
            change_q      <= 4'd0;
            refund_q      <= 1'b0;
            refund_val_q  <= 4'd0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            val_tot_q     <= val_tot_d;
            row_q         <= row_d;
            col_q         <= col_d;
            vend_q        <= vend_d;
            change_q      <= change_d;
            refund_q      <= refund_d;
            refund_val_q  <= refund_val_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign state_o       = state_q;
    assign val_tot_o     = val_tot_q;
    assign row_o         = row_q;
    assign col_o         = col_q;
    assign vend_o        = vend_q;
    assign change_o      = change_q;
    assign refund_o      = refund_q;
    assign refund_val_o  = refund_val_q;
    assign coin_reject_o = coin_reject_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios with hand-computed expected outputs.
// Two instances share the inputs: PRICE=4 (main) and PRICE=8 (credit limit cases).
module tb_vend_sequencer;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [1:0] key_row, key_col;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       cancel;

    logic [2:0] state_a, state_b;
    logic [3:0] val_tot_a, val_tot_b;
    logic [1:0] row_a, row_b, col_a, col_b;
    logic       vend_a, vend_b;
    logic [3:0] change_a, change_b;
    logic       refund_a, refund_b;
    logic [3:0] refund_val_a, refund_val_b;
    logic       coin_reject_a, coin_reject_b;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_v;

    wire [21:0] obs  = {state_a, val_tot_a, row_a, col_a, vend_a, change_a,
                        refund_a, refund_val_a, coin_reject_a};
    wire [21:0] obs8 = {state_b, val_tot_b, row_b, col_b, vend_b, change_b,
                        refund_b, refund_val_b, coin_reject_b};

    vend_sequencer #(.PRICE(4), .VALID_MASK(16'h0FFF), .SHOW_CYCLES(4), .HOLD_CYCLES(6)) dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_row_i(key_row),
        .key_col_i(key_col), .coin_valid_i(coin_valid), .coin_val_i(coin_val),
        .cancel_i(cancel), .state_o(state_a), .val_tot_o(val_tot_a), .row_o(row_a),
        .col_o(col_a), .vend_o(vend_a), .change_o(change_a), .refund_o(refund_a),
        .refund_val_o(refund_val_a), .coin_reject_o(coin_reject_a)
    );

    vend_sequencer #(.PRICE(8), .VALID_MASK(16'h0FFF), .SHOW_CYCLES(4), .HOLD_CYCLES(6)) dut8 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_row_i(key_row),
        .key_col_i(key_col), .coin_valid_i(coin_valid), .coin_val_i(coin_val),
        .cancel_i(cancel), .state_o(state_b), .val_tot_o(val_tot_b), .row_o(row_b),
        .col_o(col_b), .vend_o(vend_b), .change_o(change_b), .refund_o(refund_b),
        .refund_val_o(refund_val_b), .coin_reject_o(coin_reject_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack an expected output set in the same order as obs.
    function automatic logic [21:0] ev(input logic [2:0] st, input logic [3:0] vt,
                                       input logic [1:0] r, input logic [1:0] c,
                                       input logic v, input logic [3:0] ch,
                                       input logic rf, input logic [3:0] rv,
                                       input logic cr);
        return {st, vt, r, c, v, ch, rf, rv, cr};
    endfunction

    // One clock edge; strobes last exactly one edge, outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_valid = 1'b1; key_row = r; key_col = c;
        cyc();
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1; coin_val = v;
        cyc();
    endtask

    // Key press plus the four display cycles, ending in COIN.
    task automatic goto_coin(input logic [1:0] r, input logic [1:0] c);
        press(r, c);
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        key_valid = 1'b1; key_row = 2'd3; key_col = 2'd3;
        coin_valid = 1'b1; coin_val = 2'b00; cancel = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_v = ev(3'b000, 4'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset: got=%h exp=%h", obs, exp_v); end
        checks++;
        if (obs8 !== exp_v) begin errors++; $display("FAIL reset8: got=%h exp=%h", obs8, exp_v); end
    endtask

    task automatic test_happy();
        do_reset();
        press(2'd1, 2'd2);
        exp_v = ev(3'b001, 4'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL happy_show0: got=%h exp=%h", obs, exp_v); end
        for (int i = 1; i < 4; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL happy_show%0d: got=%h exp=%h", i, obs, exp_v); end
        end
        cyc();
        exp_v = ev(3'b010, 4'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL happy_coin_entry: got=%h exp=%h", obs, exp_v); end
        coin(2'b01);
        exp_v = ev(3'b010, 4'd2, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL happy_credit2: got=%h exp=%h", obs, exp_v); end
        coin(2'b01);
        exp_v = ev(3'b011, 4'd4, 2'd1, 2'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL happy_vend: got=%h exp=%h", obs, exp_v); end
        exp_v = ev(3'b011, 4'd4, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL happy_done%0d: got=%h exp=%h", i, obs, exp_v); end
        end
        cyc();
        exp_v = ev(3'b000, 4'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL happy_idle: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_err_id();
        do_reset();
        press(2'd3, 2'd0);
        exp_v = ev(3'b001, 4'd0, 2'd3, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL errid_show: got=%h exp=%h", obs, exp_v); end
        exp_v = ev(3'b100, 4'd0, 2'd3, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL errid_hold%0d: got=%h exp=%h", i, obs, exp_v); end
        end
        cyc();
        exp_v = ev(3'b000, 4'd0, 2'd3, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL errid_idle: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_change_and_done_inputs();
        do_reset();
        goto_coin(2'd2, 2'd1);
        coin(2'b01);
        coin(2'b10);
        exp_v = ev(3'b011, 4'd6, 2'd2, 2'd1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL change2: got=%h exp=%h", obs, exp_v); end
        // coin, key and cancel during DONE: coin rejected, the rest ignored
        coin_valid = 1'b1; coin_val = 2'b00;
        key_valid = 1'b1; key_row = 2'd0; key_col = 2'd0; cancel = 1'b1;
        cyc();
        exp_v = ev(3'b011, 4'd6, 2'd2, 2'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL done_coin_reject: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_credit_limit();
        do_reset();
        goto_coin(2'd0, 2'd0);
        coin(2'b10);
        exp_v = ev(3'b010, 4'd4, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs8 !== exp_v) begin errors++; $display("FAIL p8_credit4: got=%h exp=%h", obs8, exp_v); end
        coin(2'b01);
        coin(2'b01);
        exp_v = ev(3'b011, 4'd8, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs8 !== exp_v) begin errors++; $display("FAIL p8_vend_at8: got=%h exp=%h", obs8, exp_v); end
        do_reset();
        goto_coin(2'd0, 2'd0);
        coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        exp_v = ev(3'b010, 4'd7, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs8 !== exp_v) begin errors++; $display("FAIL p8_credit7: got=%h exp=%h", obs8, exp_v); end
        coin(2'b10);
        exp_v = ev(3'b101, 4'd7, 2'd0, 2'd0, 1'b0, 4'd0, 1'b1, 4'd11, 1'b0);
        checks++;
        if (obs8 !== exp_v) begin errors++; $display("FAIL p8_overflow: got=%h exp=%h", obs8, exp_v); end
    endtask

    task automatic test_cancel();
        do_reset();
        press(2'd1, 2'd1);
        cancel = 1'b1;
        cyc();
        exp_v = ev(3'b000, 4'd0, 2'd1, 2'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cancel_show: got=%h exp=%h", obs, exp_v); end
        goto_coin(2'd1, 2'd1);
        coin(2'b00);
        coin(2'b01);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b10;
        cyc();
        exp_v = ev(3'b000, 4'd0, 2'd1, 2'd1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cancel_coin: got=%h exp=%h", obs, exp_v); end
        coin(2'b00);
        exp_v = ev(3'b000, 4'd0, 2'd1, 2'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL idle_coin_reject: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_bad_coin();
        do_reset();
        goto_coin(2'd1, 2'd3);
        coin(2'b01);
        coin(2'b11);
        exp_v = ev(3'b101, 4'd2, 2'd1, 2'd3, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL bad_coin: got=%h exp=%h", obs, exp_v); end
        exp_v = ev(3'b101, 4'd2, 2'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL errval_hold%0d: got=%h exp=%h", i, obs, exp_v); end
        end
        cyc();
        exp_v = ev(3'b000, 4'd0, 2'd1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL errval_idle: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        goto_coin(2'd2, 2'd2);
        coin(2'b00);
        coin(2'b01);
        exp_v = ev(3'b010, 4'd3, 2'd2, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mid_credit3: got=%h exp=%h", obs, exp_v); end
        rst = 1'b1; cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b00;
        cyc();
        rst = 1'b0;
        exp_v = ev(3'b000, 4'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mid_reset: got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_row = 2'd0; key_col = 2'd0;
        coin_valid = 1'b0; coin_val = 2'b00; cancel = 1'b0;
        test_reset();
        test_happy();
        test_err_id();
        test_change_and_done_inputs();
        test_credit_limit();
        test_cancel();
        test_bad_coin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
